// File: rtl/sha256_chunk_packer.sv
// sha256_chunk_packer
// Producer side of the SHA-256 chunk interface. Accepts the message as a
// 32-bit big-endian word stream, assembles 512-bit chunks and appends the
// standard padding (0x80 marker, zero fill, 64-bit message bit length).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   buf_data_vld    input word valid
//   buf_data_rdy    input word ready (registered, high only in FILL)
//   buf_data        message word, first byte in [31:24]
//   buf_last        final word of the message
//   buf_nbytes      valid bytes in word, MSB-aligned (values >4 clamp to 4)
//   chunk_data_vld  chunk valid
//   chunk_data_rdy  chunk ready
//   chunk_data      512-bit chunk, slot 0 in [511:480], slot 15 in [31:0]
//   chunk_last      chunk carries the message length
//   err             sticky protocol error
//
// Optional feature: define SHA256_PACKER_ERR_EN to build the protocol checker
// behind err; otherwise err is tied low.
module sha256_chunk_packer (
  input  logic         clk,
  input  logic         rst,
  input  logic         buf_data_vld,
  output logic         buf_data_rdy,
  input  logic [31:0]  buf_data,
  input  logic         buf_last,
  input  logic [2:0]   buf_nbytes,
  output logic         chunk_data_vld,
  input  logic         chunk_data_rdy,
  output logic [511:0] chunk_data,
  output logic         chunk_last,
  output logic         err
);

  typedef enum logic [1:0] {FILL, PAD, OUT} state_t;

  state_t      state, state_nxt;
  logic [31:0] slot_q [16];
  logic [3:0]  idx;
  logic [63:0] nbyte;
  logic        marker_pend;
  logic        len_here;
  logic        tail_seen;
  logic        rdy_q;
  logic        last_q;

  logic [2:0]  nb;
  logic        in_hs;
  logic [31:0] tail_word;
  logic [31:0] pad_word;
  logic [63:0] bit_len;

  assign nb      = (buf_nbytes > 3'd4) ? 3'd4 : buf_nbytes;
  assign in_hs   = rdy_q & buf_data_vld;
  assign bit_len = {nbyte[60:0], 3'b000};

  // Final partial word: keep the valid bytes, marker right after them.
  always_comb begin
    tail_word = buf_data;
    case (nb)
      3'd0:    tail_word = 32'h8000_0000;
      3'd1:    tail_word = {buf_data[31:24], 24'h80_0000};
      3'd2:    tail_word = {buf_data[31:16], 16'h8000};
      3'd3:    tail_word = {buf_data[31:8], 8'h80};
      default: tail_word = buf_data;
    endcase
  end

  always_comb begin
    pad_word = '0;
    if (marker_pend)
      pad_word = 32'h8000_0000;
    else if (len_here && idx == 4'd14)
      pad_word = bit_len[63:32];
    else if (len_here && idx == 4'd15)
      pad_word = bit_len[31:0];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (in_hs && (buf_last || idx == 4'd15))
              state_nxt = (idx == 4'd15) ? OUT : PAD;
      PAD:  if (idx == 4'd15) state_nxt = OUT;
      OUT:  if (chunk_data_rdy) begin
              if (last_q)         state_nxt = FILL;
              else if (tail_seen) state_nxt = PAD;
              else                state_nxt = FILL;
            end
      default: state_nxt = FILL;
    endcase
  end

  // Outputs
  always_comb begin
    chunk_data_vld = (state == OUT);
    buf_data_rdy   = rdy_q;
    chunk_last     = last_q;
    chunk_data     = '0;
    for (int unsigned i = 0; i < 16; i++)
      chunk_data[511 - 32*i -: 32] = slot_q[i];
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 16; i++) slot_q[i] <= '0;
      idx         <= '0;
      nbyte       <= '0;
      marker_pend <= 1'b0;
      len_here    <= 1'b0;
      tail_seen   <= 1'b0;
      rdy_q       <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      rdy_q <= (state_nxt == FILL);
      case (state)
        FILL: if (in_hs) begin
          slot_q[idx] <= buf_last ? tail_word : buf_data;
          idx         <= idx + 4'd1;
          nbyte       <= nbyte + 64'(nb);
          if (buf_last) begin
            tail_seen <= 1'b1;
            if (nb == 3'd4) marker_pend <= 1'b1;
            else            len_here    <= (idx <= 4'd13);
          end
          if (idx == 4'd15) last_q <= 1'b0;
        end
        PAD: begin
          slot_q[idx] <= pad_word;
          idx         <= idx + 4'd1;
          if (marker_pend) begin
            marker_pend <= 1'b0;
            len_here    <= (idx <= 4'd13);
          end
          // A marker landing in slot 15 leaves no room for the length.
          if (idx == 4'd15) last_q <= marker_pend ? 1'b0 : len_here;
        end
        OUT: if (chunk_data_rdy) begin
          for (int unsigned i = 0; i < 16; i++) slot_q[i] <= '0;
          idx <= '0;
          if (last_q) begin
            nbyte       <= '0;
            marker_pend <= 1'b0;
            len_here    <= 1'b0;
            tail_seen   <= 1'b0;
            last_q      <= 1'b0;
          end else if (tail_seen) begin
            len_here <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHA256_PACKER_ERR_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (in_hs && !buf_last && nb != 3'd4)
      err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_chunk_packer.sv
// Directed testbench for sha256_chunk_packer.
module tb_sha256_chunk_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         buf_data_vld = 1'b0;
  logic         buf_data_rdy;
  logic [31:0]  buf_data = '0;
  logic         buf_last = 1'b0;
  logic [2:0]   buf_nbytes = 3'd4;
  logic         chunk_data_vld;
  logic         chunk_data_rdy = 1'b1;
  logic [511:0] chunk_data;
  logic         chunk_last;
  logic         err;

  sha256_chunk_packer dut (
    .clk            (clk),
    .rst            (rst),
    .buf_data_vld   (buf_data_vld),
    .buf_data_rdy   (buf_data_rdy),
    .buf_data       (buf_data),
    .buf_last       (buf_last),
    .buf_nbytes     (buf_nbytes),
    .chunk_data_vld (chunk_data_vld),
    .chunk_data_rdy (chunk_data_rdy),
    .chunk_data     (chunk_data),
    .chunk_last     (chunk_last),
    .err            (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;
  int acc_cyc = 0;

  logic [511:0] got_d;
  logic         got_last;
  int           got_lat;
  logic [31:0]  exp_s [16];

  function automatic logic [511:0] exp_chunk();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = exp_s[i];
    return r;
  endfunction

  function automatic void clr_exp();
    for (int i = 0; i < 16; i++) exp_s[i] = '0;
  endfunction

  function automatic logic [31:0] wgen(input int i);
    return {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)};
  endfunction

  // Drive one word; called and returns at a negedge. acc_cyc holds the
  // cycle count right after the accepting edge.
  task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
    int n = 0;
    buf_data = d; buf_nbytes = nb; buf_last = last; buf_data_vld = 1'b1;
    while (!buf_data_rdy && n < 100) begin @(negedge clk); n++; end
    if (!buf_data_rdy) begin
      checks++;
      $display("FAIL send_word: buf_data_rdy still 0 after 100 cycles");
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    buf_data_vld = 1'b0; buf_last = 1'b0; buf_nbytes = 3'd4;
    @(negedge clk);
  endtask

  // Capture the next chunk; latency is counted in edges after the accept
  // edge, so a chunk valid right after that edge reads 0.
  task automatic wait_chunk();
    int n = 0;
    while (!chunk_data_vld && n < 200) begin @(negedge clk); n++; end
    if (!chunk_data_vld) begin
      checks++;
      $display("FAIL wait_chunk: chunk_data_vld still 0 after 200 cycles");
    end
    got_d = chunk_data; got_last = chunk_last; got_lat = cyc - acc_cyc;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (buf_data_rdy !== 1'b0) $display("FAIL reset_rdy: got %b want 0", buf_data_rdy); else passed++;
    checks++; if (chunk_data_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", chunk_data_vld); else passed++;
    checks++; if (chunk_data !== '0) $display("FAIL reset_data: got %h want 0", chunk_data); else passed++;
    checks++; if (chunk_last !== 1'b0) $display("FAIL reset_last: got %b want 0", chunk_last); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (buf_data_rdy !== 1'b1) $display("FAIL reset_rdy_after: got %b want 1", buf_data_rdy); else passed++;
  endtask

  task automatic test_abc(input string tag);
    send_word(32'h6162_6300, 3'd3, 1'b1);
    wait_chunk();
    clr_exp(); exp_s[0] = 32'h6162_6380; exp_s[15] = 32'h0000_0018;
    checks++; if (got_d !== exp_chunk()) $display("FAIL %s_data: got %h want %h", tag, got_d, exp_chunk()); else passed++;
    checks++; if (got_last !== 1'b1) $display("FAIL %s_last: got %b want 1", tag, got_last); else passed++;
    checks++; if (got_lat !== 15) $display("FAIL %s_latency: got %0d want 15", tag, got_lat); else passed++;
  endtask

  task automatic test_empty();
    send_word(32'hDEAD_BEEF, 3'd0, 1'b1);
    wait_chunk();
    clr_exp(); exp_s[0] = 32'h8000_0000;
    checks++; if (got_d !== exp_chunk()) $display("FAIL empty_data: got %h want %h", got_d, exp_chunk()); else passed++;
    checks++; if (got_last !== 1'b1) $display("FAIL empty_last: got %b want 1", got_last); else passed++;
  endtask

  task automatic test_56_bytes();
    for (int i = 0; i < 14; i++) send_word(wgen(i), 3'd4, i == 13);
    wait_chunk();
    clr_exp();
    for (int i = 0; i < 14; i++) exp_s[i] = wgen(i);
    exp_s[14] = 32'h8000_0000;
    checks++; if (got_d !== exp_chunk()) $display("FAIL b56_a_data: got %h want %h", got_d, exp_chunk()); else passed++;
    checks++; if (got_last !== 1'b0) $display("FAIL b56_a_last: got %b want 0", got_last); else passed++;
    checks++; if (got_lat !== 2) $display("FAIL b56_a_latency: got %0d want 2", got_lat); else passed++;
    wait_chunk();
    clr_exp(); exp_s[15] = 32'h0000_01C0;
    checks++; if (got_d !== exp_chunk()) $display("FAIL b56_b_data: got %h want %h", got_d, exp_chunk()); else passed++;
    checks++; if (got_last !== 1'b1) $display("FAIL b56_b_last: got %b want 1", got_last); else passed++;
  endtask

  task automatic test_64_bytes();
    for (int i = 0; i < 16; i++) send_word(wgen(i + 20), 3'd4, i == 15);
    wait_chunk();
    clr_exp();
    for (int i = 0; i < 16; i++) exp_s[i] = wgen(i + 20);
    checks++; if (got_d !== exp_chunk()) $display("FAIL b64_a_data: got %h want %h", got_d, exp_chunk()); else passed++;
    checks++; if (got_last !== 1'b0) $display("FAIL b64_a_last: got %b want 0", got_last); else passed++;
    checks++; if (got_lat !== 0) $display("FAIL b64_a_latency: got %0d want 0", got_lat); else passed++;
    wait_chunk();
    clr_exp(); exp_s[0] = 32'h8000_0000; exp_s[15] = 32'h0000_0200;
    checks++; if (got_d !== exp_chunk()) $display("FAIL b64_b_data: got %h want %h", got_d, exp_chunk()); else passed++;
    checks++; if (got_last !== 1'b1) $display("FAIL b64_b_last: got %b want 1", got_last); else passed++;
    checks++; if (got_lat !== 17) $display("FAIL b64_b_latency: got %0d want 17", got_lat); else passed++;
  endtask

  task automatic test_backpressure();
    logic [511:0] cap;
    int n = 0;
    chunk_data_rdy = 1'b0;
    send_word(32'h6162_6300, 3'd3, 1'b1);
    while (!chunk_data_vld && n < 200) begin @(negedge clk); n++; end
    cap = chunk_data;
    clr_exp(); exp_s[0] = 32'h6162_6380; exp_s[15] = 32'h0000_0018;
    checks++; if (cap !== exp_chunk()) $display("FAIL bp_data: got %h want %h", cap, exp_chunk()); else passed++;
    // A stray word offered while not ready must be ignored.
    buf_data = 32'hDEAD_BEEF; buf_nbytes = 3'd4; buf_last = 1'b0; buf_data_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (chunk_data !== cap || chunk_data_vld !== 1'b1 || buf_data_rdy !== 1'b0)
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b data=%h want vld=1 rdy=0 data=%h",
                 i, chunk_data_vld, buf_data_rdy, chunk_data, cap);
      else passed++;
    end
    buf_data_vld = 1'b0;
    chunk_data_rdy = 1'b1;
    @(posedge clk); #1;
    checks++; if (buf_data_rdy !== 1'b1) $display("FAIL bp_release_rdy: got %b want 1", buf_data_rdy); else passed++;
    checks++; if (chunk_data_vld !== 1'b0) $display("FAIL bp_release_vld: got %b want 0", chunk_data_vld); else passed++;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) send_word(wgen(i + 40), 3'd4, 1'b0);
    rst = 1'b1;
    #1;
    checks++; if (buf_data_rdy !== 1'b0) $display("FAIL midrst_rdy: got %b want 0", buf_data_rdy); else passed++;
    checks++; if (chunk_data !== '0) $display("FAIL midrst_data: got %h want 0", chunk_data); else passed++;
    checks++; if (chunk_data_vld !== 1'b0 || chunk_last !== 1'b0)
      $display("FAIL midrst_vld_last: got vld=%b last=%b want 0 0", chunk_data_vld, chunk_last); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_abc("abc_after_rst");
  endtask

  task automatic test_err();
    logic exp_err;
`ifdef SHA256_PACKER_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    send_word(32'h1122_3300, 3'd2, 1'b0);
    checks++; if (err !== exp_err) $display("FAIL err_set: got %b want %b", err, exp_err); else passed++;
    send_word(32'h4455_6677, 3'd4, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (err !== exp_err) $display("FAIL err_sticky: got %b want %b", err, exp_err); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (err !== 1'b0) $display("FAIL err_reset: got %b want 0", err); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_abc("abc");
    test_empty();
    test_56_bytes();
    test_64_bytes();
    test_backpressure();
    test_abc("abc_after_bp");
    test_mid_reset();
    test_err();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/sha256_chunk_packer.md
# sha256_chunk_packer

Producer side of the SHA-256 transform's chunk interface. It accepts the message as a 32-bit big-endian word stream, assembles 512-bit chunks, and applies the standard SHA-256 padding: a 0x80 marker, zero fill, and the 64-bit message bit length. Padded chunks are presented on a valid/ready port that feeds `sha256_transform`'s `chunk_data` input directly. This replaces the constant-chunk stub in the `sha256` top.

## Interface
- No parameters; word width 32, chunk width 512, length field 64 are fixed.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `buf_data_vld`  in  1  input word valid
- `buf_data_rdy`  out  1  input word ready
- `buf_data`  in  32  message word; first byte in [31:24]
- `buf_last`  in  1  word is the final word of the message
- `buf_nbytes`  in  3  valid bytes in word, MSB-aligned; must be 4 unless `buf_last`; 0 allowed only with `buf_last` (empty tail); values >4 treated as 4
- `chunk_data_vld`  out  1  chunk valid
- `chunk_data_rdy`  in  1  chunk ready
- `chunk_data`  out  512  chunk; slot 0 in [511:480], slot 15 in [31:0]
- `chunk_last`  out  1  chunk is the final (length-bearing) chunk of the message
- `err`  out  1  sticky protocol error (see Configuration)

## Operation
- The block holds a 16-slot buffer, a 4-bit slot index `idx`, a 64-bit byte counter `nbyte`, a `marker_pend` flag, and a `len_here` flag.
- FSM states: FILL, PAD, OUT.
- **FILL**
  - `buf_data_rdy`=1.
  - On each handshake, write slot `idx` and increment `idx`; `nbyte += nbytes`.
  - Non-last word: if the write filled slot 15, go to OUT with `chunk_last`=0.
  - Last word with nbytes<4: write the word with unused bytes zeroed and 0x80 placed in byte position `nbytes`. Set `len_here` = (slot ≤ 13).
  - Last word with nbytes=4: write the word unchanged and set `marker_pend`=1.
  - After a last word, go to PAD, or to OUT if the write filled slot 15.
- **PAD**
  - One slot written per cycle.
  - If `marker_pend`: write 0x80000000, clear `marker_pend`, set `len_here` = (idx ≤ 13).
  - Else if `len_here` and idx=14: write (nbyte<<3)[63:32].
  - Else if `len_here` and idx=15: write (nbyte<<3)[31:0].
  - Else write 0.
  - After slot 15 is written, go to OUT.
  - `chunk_last` = `len_here`.
- **OUT**
  - `chunk_data_vld`=1; `chunk_data` and `chunk_last` are held stable until `chunk_data_rdy`.
  - On handshake, `idx`←0 and the buffer is cleared to zero.
  - If `chunk_last`: go to FILL and clear `nbyte` and the flags.
  - Else if the message tail is pending (last word already seen): go to PAD with `len_here`=1, producing an all-zero chunk with the length.
  - Else go to FILL.
- Length arithmetic is modulo 2^64; the bit length is `nbyte` shifted left by 3, truncated to 64 bits.
- Reset values: `buf_data_rdy`=0 during reset and 1 in the first cycle after deassertion. `chunk_data_vld`=0, `chunk_data`=0, `chunk_last`=0, `err`=0, state FILL, all counters and flags 0.
- Reset asserted mid-message or mid-OUT discards all state immediately; no partial chunk is emitted.

## Timing
- `buf_data_rdy` is registered and equals (state==FILL). It is never asserted in PAD or OUT.
- Full chunk without padding: the handshake that writes slot 15 at cycle t gives `chunk_data_vld`=1 at t+1.
- Padding latency: a last word written to slot k at cycle t gives `chunk_data_vld` at t+(15−k)+1. Example: slot 0 gives valid at t+16.
- An OUT handshake at cycle t gives `buf_data_rdy` or PAD activity at t+1. Throughput is at most one chunk per 17 cycles.
- Inputs are ignored while `buf_data_rdy`=0; `buf_data_vld` may remain asserted.

## Configuration
- `SHA256_PACKER_ERR_EN` defined:
  - `err` is set when a non-last word has nbytes≠4, or when nbytes=0 arrives without `buf_last`.
  - It stays set until reset.
  - The offending word is still consumed, using its clamped byte count.
- Not defined: `err` is tied to 0 and no checking logic is built. Datapath behaviour is identical in both cases.

## Test plan
- "abc": one word 0x61626300, nbytes=3, last → single chunk; slot0=0x61626380, slots1–14=0, slot15=0x00000018, `chunk_last`=1, valid 16 cycles after accept.
- Empty message: nbytes=0, last → slot0=0x80000000, slots1–15=0, `chunk_last`=1.
- 56-byte message (14 full words, last on 14th) → chunk A: slot14=0x80000000, slot15=0, `chunk_last`=0; chunk B: all zero except slot15=0x000001C0, `chunk_last`=1.
- 64-byte message (16 words, last on 16th) → chunk A = data, `chunk_last`=0; chunk B: slot0=0x80000000, slot15=0x00000200, `chunk_last`=1.
- Backpressure: hold `chunk_data_rdy`=0 for 10 cycles in OUT → `chunk_data` stable, `buf_data_rdy`=0 throughout. Then rdy=1 → `buf_data_rdy`=1 on the next cycle.
- Assert `rst` after 5 words of a message → outputs return to reset values. A following "abc" message yields exactly the "abc" chunk with length 0x18. With `SHA256_PACKER_ERR_EN`: a non-last word with nbytes=2 sets `err`=1, which holds until `rst`.
